// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank
//  Description : Single-port synchronous RAM bank with byte write enables,
//                registered read-valid and a hardware clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     S_addr,
    input  logic [DATA_W-1:0]     S_din,
    input  logic                  clr,
    output logic [DATA_W-1:0]     S_dout,
    output logic                  S_valid,
    output logic                  busy
);

    localparam int                c_NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_in_range;
    logic                w_clr_wr;
    logic                w_wr;
    logic                w_rd;
    logic [DATA_W-1:0]   w_rd_data;

    // Addresses beyond DEPTH only exist when the bank is not a full power of two.
    assign w_in_range = ({1'b0, S_addr} < c_DEPTH);
    assign w_rd_data  = w_in_range ? r_mem[S_addr] : '0;
    assign busy       = (r_state == S_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_wr    = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_wr = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                // A clear request wins over any access presented alongside it.
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (cen) begin
                    w_wr = wen;
                    w_rd = !wen;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            S_dout  <= '0;
            S_valid <= 1'b0;
        end else if (w_rd) begin
            S_dout  <= w_rd_data;
            S_valid <= 1'b1;
        end else begin
            S_dout  <= '0;
            S_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_clr_wr) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr && w_in_range) begin
                for (int k = 0; k < c_NB; k++) begin
                    if (be[k]) begin
                        r_mem[S_addr][8*k +: 8] <= S_din[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bank
//  Description : Randomised self-checking bench for sram_bank (32x32 bank with
//                reference model, plus a 64-bit 12-word bank checked directly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bank A: DATA_W=32, ADDR_W=5, DEPTH=32
    logic        rn_a = 1'b0, cen_a = 1'b0, wen_a = 1'b0, clr_a = 1'b0;
    logic [3:0]  be_a = '0;
    logic [4:0]  addr_a = '0;
    logic [31:0] din_a = '0;
    logic [31:0] dout_a;
    logic        valid_a, busy_a;

    // Bank B: DATA_W=64, ADDR_W=4, DEPTH=12
    logic        rn_b = 1'b0, cen_b = 1'b0, wen_b = 1'b0, clr_b = 1'b0;
    logic [7:0]  be_b = '0;
    logic [3:0]  addr_b = '0;
    logic [63:0] din_b = '0;
    logic [63:0] dout_b;
    logic        valid_b, busy_b;

    sram_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) u_dut_a (
        .clk(clk), .reset_n(rn_a), .cen(cen_a), .wen(wen_a), .be(be_a),
        .S_addr(addr_a), .S_din(din_a), .clr(clr_a),
        .S_dout(dout_a), .S_valid(valid_a), .busy(busy_a)
    );

    sram_bank #(.DATA_W(64), .ADDR_W(4), .DEPTH(12)) u_dut_b (
        .clk(clk), .reset_n(rn_b), .cen(cen_b), .wen(wen_b), .be(be_b),
        .S_addr(addr_b), .S_din(din_b), .clr(clr_b),
        .S_dout(dout_b), .S_valid(valid_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of bank A
    logic [31:0] m_mem [32];
    bit          m_clearing = 1'b0;
    int          m_ccnt     = 0;
    logic [31:0] exp_dout   = '0;
    bit          exp_valid  = 1'b0;
    bit          exp_busy   = 1'b0;
    bit          cmp_en     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle on bank A, advance the model, commit expectations at the edge.
    task automatic step(input bit rn, input bit c, input bit w, input logic [3:0] b,
                        input logic [4:0] a, input logic [31:0] d, input bit cl);
        logic [31:0] pd;
        bit          pv;
        rn_a = rn; cen_a = c; wen_a = w; be_a = b; addr_a = a; din_a = d; clr_a = cl;
        pd = '0;
        pv = 1'b0;
        if (!rn) begin
            m_clearing = 1'b1;
            m_ccnt     = 0;
        end else if (m_clearing) begin
            m_mem[m_ccnt] = '0;
            m_ccnt++;
            if (m_ccnt == 32) m_clearing = 1'b0;
        end else if (cl) begin
            m_clearing = 1'b1;
            m_ccnt     = 0;
        end else if (c && w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
        end else if (c) begin
            pd = m_mem[a];
            pv = 1'b1;
        end
        @(posedge clk);
        exp_dout  = pd;
        exp_valid = pv;
        exp_busy  = m_clearing;
        if (!rn) cmp_en = 1'b1;
        #1;
    endtask

    task automatic rand_step(input bit allow_clr);
        step(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
             5'($urandom), $urandom, allow_clr && ($urandom_range(0, 63) == 0));
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
    endtask

    // Counts cycles busy stays high, starting right after the edge that began the clear.
    task automatic count_busy_a(input bit randomise, output int n);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            if (randomise) rand_step(1'b1);
            else idle_step();
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks += 3;
            if (busy_a !== exp_busy) begin
                n_fail++;
                $display("FAIL cmp_busy: got %0b, expected %0b", busy_a, exp_busy);
            end
            if (valid_a !== exp_valid) begin
                n_fail++;
                $display("FAIL cmp_valid: got %0b, expected %0b", valid_a, exp_valid);
            end
            if (dout_a !== exp_dout) begin
                n_fail++;
                $display("FAIL cmp_dout: got %0h, expected %0h", dout_a, exp_dout);
            end
        end
    end

    task automatic stepb(input bit rn, input bit c, input bit w, input logic [7:0] b,
                         input logic [3:0] a, input logic [63:0] d, input bit cl);
        rn_b = rn; cen_b = c; wen_b = w; be_b = b; addr_b = a; din_b = d; clr_b = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (busy_b && n < 100) begin
            n++;
            stepb(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0);
        end
    endtask

    initial begin
        int n;

        // Reset and initial clear of bank A
        step(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
        chk("reset_dout", {32'h0, dout_a}, 64'h0);
        chk("reset_valid", {63'h0, valid_a}, 64'h0);
        chk("reset_busy", {63'h0, busy_a}, 64'h1);
        count_busy_a(1'b0, n);
        chk("busy_len_reset", 64'(n), 64'd32);
        for (int a = 0; a < 32; a++) step(1'b1, 1'b1, 1'b0, 4'h0, 5'(a), 32'h0, 1'b0);

        // Full and partial byte writes
        step(1'b1, 1'b1, 1'b1, 4'b1111, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("write_valid", {63'h0, valid_a}, 64'h0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 5'd5, 32'h0, 1'b0);
        chk("rd_deadbeef", {32'h0, dout_a}, 64'hDEADBEEF);
        chk("rd_deadbeef_valid", {63'h0, valid_a}, 64'h1);
        step(1'b1, 1'b1, 1'b1, 4'b0101, 5'd5, 32'h11223344, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b1111, 5'd5, 32'h0, 1'b0);
        chk("rd_partial", {32'h0, dout_a}, 64'hDE22BE44);
        for (int i = 0; i < 3; i++) idle_step();
        chk("idle_dout", {32'h0, dout_a}, 64'h0);

        // Fill with nonzero data, then clear with a colliding write
        for (int a = 0; a < 32; a++)
            step(1'b1, 1'b1, 1'b1, 4'hF, 5'(a), $urandom | 32'h1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 5'd3, 32'hA5A5A5A5, 1'b1);
        count_busy_a(1'b1, n);
        chk("busy_len_clr", 64'(n), 64'd32);
        step(1'b1, 1'b1, 1'b0, 4'h0, 5'd3, 32'h0, 1'b0);
        chk("rd_after_clr", {31'h0, valid_a, dout_a}, 64'h1_0000_0000);
        for (int a = 0; a < 32; a++) step(1'b1, 1'b1, 1'b0, 4'h0, 5'(a), 32'h0, 1'b0);

        // Reset in the middle of a clear restarts it
        step(1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 9; i++) rand_step(1'b1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
        count_busy_a(1'b0, n);
        chk("busy_len_midreset", 64'(n), 64'd32);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) rand_step(1'b1);
        cmp_en = 1'b0;

        // Bank B: 64-bit words, 12 of 16 addresses populated
        stepb(1'b0, 1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b0);
        count_busy_b(n);
        chk("b_busy_len", 64'(n), 64'd12);
        stepb(1'b1, 1'b1, 1'b1, 8'hFF, 4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        stepb(1'b1, 1'b1, 1'b0, 8'h00, 4'd13, 64'h0, 1'b0);
        chk("b_rd_oor_dout", dout_b, 64'h0);
        chk("b_rd_oor_valid", {63'h0, valid_b}, 64'h1);
        stepb(1'b1, 1'b1, 1'b1, 8'hFF, 4'd11, 64'h0123_4567_89AB_CDEF, 1'b0);
        stepb(1'b1, 1'b1, 1'b1, 8'h0F, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        stepb(1'b1, 1'b1, 1'b0, 8'h00, 4'd11, 64'h0, 1'b0);
        chk("b_rd_partial", dout_b, 64'h0123_4567_FFFF_FFFF);
        stepb(1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 64'hCAFE, 1'b1);
        for (int i = 0; i < 4; i++) stepb(1'b1, 1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b0);
        stepb(1'b0, 1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b0);
        count_busy_b(n);
        chk("b_busy_len_midreset", 64'(n), 64'd12);
        stepb(1'b1, 1'b1, 1'b0, 8'h00, 4'd11, 64'h0, 1'b0);
        chk("b_rd_cleared", {dout_b[62:0], valid_b}, 64'h1);
        stepb(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 64'h0, 1'b0);
        chk("b_rd_dropped_wr", {dout_b[62:0], valid_b}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
